// File: rtl/sram_burst_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// sram_burst_ctrl_fsm
// Burst SRAM access sequencer. Accepts one read or write request of 1..MAX_BURST
// words and walks every beat through SETUP -> READ/WRITE -> STABLE, incrementing
// the array address (wrapping modulo 2^ADDR_W) between beats.
//
// Optional feature macro: FSM_RDBACK_EN
//   defined   : after each write beat the array output is compared with the word
//               written; a mismatch sets the sticky err flag (cleared by reset or
//               by the next accepted request).
//   undefined : no compare logic, err is tied low.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   selFSM, req         block select and request strobe (sampled in IDLE only)
//   op                  1 = write, 0 = read (latched at accept)
//   addr, burst_len     start address and beats-1 (latched at accept)
//   wr_data             write word of the current beat, consumed when wr_ready=1
//   mem_rdata           read data from the array
//   req_ready           high in IDLE
//   wr_ready            one-cycle pulse in WRITE
//   rd_data, rd_valid   captured read word, and its one-cycle update pulse
//   mem_addr, mem_wdata array address and write data (write data 0 unless mem_we)
//   mem_en, mem_we      array enable (any non-IDLE state) and write enable (WRITE)
//   rw                  latched op while busy, 0 in IDLE
//   valid               array settled (STABLE)
//   done                pulse in the last STABLE cycle of the final beat
//   err                 readback mismatch flag
// -----------------------------------------------------------------------------
module sram_burst_ctrl_fsm #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STABLE_CYC = 2,
    parameter int MAX_BURST  = 4,
    parameter int LEN_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              selFSM,
    input  logic              req,
    input  logic              op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              req_ready,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic              rw,
    output logic              valid,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        READ   = 3'd2,
        WRITE  = 3'd3,
        STABLE = 3'd4
    } state_t;

    // One phase counter serves both SETUP and STABLE, so size it for the longer.
    localparam int CYC_MAX = (SETUP_CYC > STABLE_CYC) ? SETUP_CYC : STABLE_CYC;
    localparam int CNT_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

    state_t            state_reg,  state_next;
    logic [CNT_W-1:0]  cnt_reg,    cnt_next;
    logic [LEN_W-1:0]  beats_reg,  beats_next;
    logic [ADDR_W-1:0] addr_reg,   addr_next;
    logic              op_reg,     op_next;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;
    logic              accept;
    logic              done_next;

    logic setup_last;
    logic stable_last;
    assign setup_last  = (cnt_reg == CNT_W'(SETUP_CYC - 1));
    assign stable_last = (cnt_reg == CNT_W'(STABLE_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            beats_reg <= '0;
            addr_reg  <= '0;
            op_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            beats_reg <= beats_next;
            addr_reg  <= addr_next;
            op_reg    <= op_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        beats_next = beats_reg;
        addr_next  = addr_reg;
        op_next    = op_reg;
        accept     = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (selFSM && req) begin
                    accept     = 1'b1;
                    op_next    = op;
                    addr_next  = addr;
                    beats_next = burst_len;
                    cnt_next   = '0;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (setup_last) begin
                    cnt_next   = '0;
                    state_next = op_reg ? WRITE : READ;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            READ, WRITE: begin
                cnt_next   = '0;
                state_next = STABLE;
            end
            STABLE: begin
                if (stable_last) begin
                    cnt_next = '0;
                    if (beats_reg == '0) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        beats_next = beats_reg - LEN_W'(1);
                        addr_next  = addr_reg + ADDR_W'(1);
                        state_next = SETUP;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Read capture: the array word is sampled at the end of the READ cycle and
    // announced with a pulse in the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= (state_reg == READ);
            if (state_reg == READ) begin
                rd_data_reg <= mem_rdata;
            end
        end
    end

`ifdef FSM_RDBACK_EN
    logic [DATA_W-1:0] wdata_reg;
    logic              err_reg;

    // The written word is remembered so it can be compared once the array has
    // settled at the end of the beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (state_reg == WRITE) begin
                wdata_reg <= wr_data;
            end
            if (accept) begin
                err_reg <= 1'b0;
            end else if ((state_reg == STABLE) && stable_last && op_reg &&
                         (mem_rdata != wdata_reg)) begin
                err_reg <= 1'b1;
            end
        end
    end
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign req_ready = (state_reg == IDLE);
    assign mem_en    = (state_reg == SETUP) || (state_reg == READ) ||
                       (state_reg == WRITE) || (state_reg == STABLE);
    assign mem_we    = (state_reg == WRITE);
    assign wr_ready  = mem_we;
    assign mem_wdata = mem_we ? wr_data : '0;
    assign mem_addr  = addr_reg;
    assign rw        = mem_en & op_reg;
    assign valid     = (state_reg == STABLE);
    assign done      = done_next;
    assign rd_data   = rd_data_reg;
    assign rd_valid  = rd_valid_reg;

endmodule

// File: tb/tb_sram_burst_ctrl_fsm.sv
module tb_sram_burst_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       selFSM = 1'b0;
    logic       req = 1'b0;
    logic       op = 1'b0;
    logic [3:0] addr = '0;
    logic [1:0] burst_len = '0;
    logic [7:0] wr_data;
    logic [7:0] mem_rdata;
    logic       req_ready, wr_ready, rd_valid, mem_en, mem_we, rw, valid, done, err;
    logic [7:0] rd_data, mem_wdata;
    logic [3:0] mem_addr;

    sram_burst_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .selFSM(selFSM), .req(req), .op(op),
        .addr(addr), .burst_len(burst_len), .wr_data(wr_data),
        .mem_rdata(mem_rdata), .req_ready(req_ready), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_we(mem_we), .rw(rw),
        .valid(valid), .done(done), .err(err)
    );

    always #5 clk = ~clk;

`ifdef FSM_RDBACK_EN
    localparam logic EXP_RDBACK_ERR = 1'b1;
`else
    localparam logic EXP_RDBACK_ERR = 1'b0;
`endif

    // Array model: preset pattern on reset, written by mem_we.
    logic [7:0] tbmem [16];
    logic [7:0] ref_mem [16];
    logic [7:0] corrupt = 8'h00;
    logic [7:0] cur_base = 8'h00;
    int         wr_cnt = 0;
    int         wr_start = 0;

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 29 + 7);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) tbmem[i] <= pat(i);
        end else if (mem_we) begin
            tbmem[mem_addr] <= mem_wdata;
        end
    end

    always @(posedge clk) if (wr_ready) wr_cnt <= wr_cnt + 1;

    assign wr_data   = cur_base + 8'(wr_cnt - wr_start);
    assign mem_rdata = tbmem[mem_addr] ^ corrupt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        int         cyc;
    } beat_t;
    beat_t sb[$];

    typedef struct {
        logic       op;
        logic [3:0] addr;
        logic [1:0] len;
        logic [7:0] base;
        int         cycles;
    } vec_t;
    vec_t vecs[7];

    // Called at a negedge. Without b2b the DUT must be idle now; with b2b the
    // DUT is in the done cycle of a previous transaction.
    task automatic run_txn(input logic o, input logic [3:0] a, input logic [1:0] l,
                           input logic [7:0] b, input int exp_cyc,
                           input bit hold, input bit b2b);
        bit         finished;
        int         wr_seen;
        int         c;
        logic [3:0] ba;
        beat_t      e;
        selFSM = 1'b1; req = 1'b1; op = o; addr = a; burst_len = l;
        cur_base = b; wr_start = wr_cnt;
        for (int i = 0; i <= int'(l); i++) begin
            ba = a + 4'(i);
            if (o) begin
                ref_mem[ba] = b + 8'(i);
                sb.push_back('{ba, b + 8'(i), 2 + 4 * i});
            end else begin
                sb.push_back('{ba, ref_mem[ba], 3 + 4 * i});
            end
        end
        if (b2b) begin
            @(posedge clk); @(negedge clk);
            chk("b2b_idle_cycle", req_ready, 1);
        end
        @(posedge clk);
        finished = 0;
        wr_seen  = 0;
        for (c = 1; c <= 200 && !finished; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("accept_req_ready", req_ready, 0);
                chk("accept_rw", rw, o);
                if (!hold) begin
                    req = 1'b0;
                    selFSM = 1'b0;
                end
            end
            chk("busy_mem_en", mem_en, 1);
            chk("valid_phase", valid, (((c - 1) % 4) >= 2) ? 1 : 0);
            chk("err_during_txn", err, 0);
            if (mem_we) begin
                wr_seen++;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_write", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", mem_addr, e.a);
                    chk("wr_data", mem_wdata, e.d);
                    chk("wr_cycle", c, e.cyc);
                    chk("wr_ready", wr_ready, 1);
                end
            end else begin
                chk("wdata_zero", mem_wdata, 0);
            end
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_read", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rd_addr", mem_addr, e.a);
                    chk("rd_data", rd_data, e.d);
                    chk("rd_cycle", c, e.cyc);
                end
            end
            if (done) begin
                chk("done_cycle", c, exp_cyc);
                chk("sb_empty", sb.size(), 0);
                if (o) chk("wr_pulses", wr_seen, int'(l) + 1);
                finished = 1;
            end
        end
        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL txn_timeout: no done within 200 cycles (op %0d addr %0h)", o, a);
            sb.delete();
        end
        $display("txn op=%0d addr=%0h len=%0d cycles=%0d", o, a, l, c - 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int bad;
        for (int i = 0; i < 16; i++) ref_mem[i] = pat(i);
        vecs[0] = '{1'b1, 4'h3, 2'd0, 8'hA5, 4};
        vecs[1] = '{1'b0, 4'h3, 2'd0, 8'h00, 4};
        vecs[2] = '{1'b1, 4'hE, 2'd3, 8'h40, 16};
        vecs[3] = '{1'b0, 4'hE, 2'd3, 8'h00, 16};
        vecs[4] = '{1'b0, 4'h6, 2'd1, 8'h00, 8};
        vecs[5] = '{1'b1, 4'h9, 2'd2, 8'h90, 12};
        vecs[6] = '{1'b0, 4'h8, 2'd3, 8'h00, 16};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rw", rw, 0);
        chk("rst_valid", valid, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset during the WRITE cycle of a burst aborts at once.
        selFSM = 1'b1; req = 1'b1; op = 1'b1; addr = 4'h8; burst_len = 2'd3;
        cur_base = 8'hC0; wr_start = wr_cnt;
        @(posedge clk);
        found = 0;
        for (int c = 1; c <= 8 && !found; c++) begin
            @(negedge clk);
            if (c == 1) begin req = 1'b0; selFSM = 1'b0; end
            if (mem_we) found = 1;
        end
        chk("rst_mid_reach_write", found, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_req_ready", req_ready, 1);
        chk("rst_mid_mem_we", mem_we, 0);
        chk("rst_mid_mem_en", mem_en, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_rw", rw, 0);
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || mem_en) bad++;
        end
        chk("rst_mid_no_resume", bad, 0);
        $display("txn reset-mid-write checked");

        // Table-driven transactions
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            chk("idle_after_done", req_ready, 1);
            run_txn(vecs[v].op, vecs[v].addr, vecs[v].len, vecs[v].base,
                    vecs[v].cycles, 1'b0, 1'b0);
        end

        // req without selFSM is ignored
        @(negedge clk);
        selFSM = 1'b0; req = 1'b1; op = 1'b0; addr = 4'h6; burst_len = 2'd0;
        repeat (10) begin
            @(negedge clk);
            chk("nosel_mem_en", mem_en, 0);
            chk("nosel_req_ready", req_ready, 1);
        end
        run_txn(1'b0, 4'h6, 2'd0, 8'h00, 4, 1'b0, 1'b0);

        // Back-to-back: req held across done, the second request changes op.
        @(negedge clk);
        run_txn(1'b0, 4'h3, 2'd0, 8'h00, 4, 1'b1, 1'b0);
        run_txn(1'b1, 4'h5, 2'd0, 8'h77, 4, 1'b0, 1'b1);

        // Readback mismatch: array returns the written word with bit 0 flipped.
        @(negedge clk);
        corrupt = 8'h01;
        run_txn(1'b1, 4'h2, 2'd0, 8'h3C, 4, 1'b0, 1'b0);
        @(negedge clk);
        corrupt = 8'h00;
        chk("rdback_err_set", err, EXP_RDBACK_ERR);
        repeat (3) begin
            @(negedge clk);
            chk("rdback_err_sticky", err, EXP_RDBACK_ERR);
        end
        run_txn(1'b0, 4'h2, 2'd0, 8'h00, 4, 1'b0, 1'b0);
        @(negedge clk);
        chk("final_idle", req_ready, 1);
        chk("final_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
